// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch slice.
//   - FSM state encodings (legacy-compatible localparam constants)
//   - ZERO_WORD, the value driven on instF when no instruction is presented
//   - small PC helpers shared by the fetch datapath
// No ports: this file is a package imported by fetch_unit and fetch_perf.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  // Fetch FSM states
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Sequential successor of a PC; wraps modulo 2^32 by construction.
  function automatic logic [31:0] pcNext(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  // Memory addresses are always word aligned, whatever a redirect supplies.
  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_perf.sv
// -----------------------------------------------------------------------------
// fetch_perf
// Performance counters for the fetch unit. Only instantiated by fetch_unit
// when FETCH_PERF_CNT_EN is defined.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset, clears both counters
//   i_fetchInc   in   one instruction handed to IF/ID this cycle
//   i_cancelInc  in   one memory response discarded this cycle
//   o_fetchCnt   out  32-bit count of delivered instructions (wraps)
//   o_cancelCnt  out  32-bit count of discarded responses (wraps)
// -----------------------------------------------------------------------------
module fetch_perf
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetchInc,
  input  logic        i_cancelInc,
  output logic [31:0] o_fetchCnt,
  output logic [31:0] o_cancelCnt
);

  logic [31:0] r_fetchCnt;
  logic [31:0] r_cancelCnt;

  // Free-running event counters; natural 32-bit overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchCnt  <= ZERO_WORD;
      r_cancelCnt <= ZERO_WORD;
    end else begin
      if (i_fetchInc) begin
        r_fetchCnt <= r_fetchCnt + 32'd1;
      end
      if (i_cancelInc) begin
        r_cancelCnt <= r_cancelCnt + 32'd1;
      end
    end
  end

  assign o_fetchCnt  = r_fetchCnt;
  assign o_cancelCnt = r_cancelCnt;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Single-outstanding-request instruction fetch stage. A three-state FSM
// (REQ -> WAIT -> HOLD) issues one memory read, waits for its data, then holds
// the instruction for IF/ID until it is accepted. Redirects replace the PC in
// any state; a response already in flight when a redirect hits is discarded.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_cnt/cancel_cnt
// outputs backed by the fetch_perf counter sub-module.
//
// Parameters:
//   RESET_PC     PC loaded on reset (default 32'hBFC0_0000)
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   stallF       in   IF/ID not accepting, hold the presented instruction
//   redirect     in   branch/jump/exception redirect this cycle
//   redirect_pc  in   redirect target
//   imem_req     out  fetch request
//   imem_addr    out  word-aligned fetch address
//   imem_ready   in   memory accepts the request this cycle
//   imem_rvalid  in   read data valid
//   imem_rdata   in   returned instruction
//   pcPlus4F     out  PC of presented instruction plus 4
//   instF        out  presented instruction, zero when validF is low
//   validF       out  instF/pcPlus4F carry a real instruction
//   fetch_cnt    out  (FETCH_PERF_CNT_EN) delivered instruction count
//   cancel_cnt   out  (FETCH_PERF_CNT_EN) discarded response count
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcPlus4F,
  output logic [31:0] instF,
  output logic        validF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] cancel_cnt
`endif
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pcReq;
  logic [31:0] r_instBuf;
  logic        r_cancel;

  logic w_inReq;
  logic w_inWait;
  logic w_inHold;
  logic w_accept;
  logic w_respKeep;
  logic w_respDrop;
  logic w_holdRelease;

  assign w_inReq  = (r_state == ST_REQ);
  assign w_inWait = (r_state == ST_WAIT);
  assign w_inHold = (r_state == ST_HOLD);

  // A redirect gates the request so a stale-PC fetch is never issued.
  assign imem_req  = w_inReq & ~redirect;
  assign imem_addr = wordAlign(r_pc);
  assign w_accept  = imem_req & imem_ready;

  // A response is kept only if nothing redirected the PC since it was issued.
  // Responses outside WAIT are not qualified at all and so are ignored.
  assign w_respKeep    = w_inWait & imem_rvalid & ~r_cancel & ~redirect;
  assign w_respDrop    = w_inWait & imem_rvalid & (r_cancel | redirect);
  assign w_holdRelease = w_inHold & ~stallF & ~redirect;

  assign validF   = w_inHold & ~redirect;
  assign instF    = validF ? r_instBuf : ZERO_WORD;
  assign pcPlus4F = w_inHold ? pcNext(r_pcReq) : pcNext(r_pc);

  // FSM, request bookkeeping and instruction buffer. The cancel flag remembers
  // that the outstanding request belongs to a PC that has since been replaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_REQ;
      r_pcReq   <= RESET_PC;
      r_instBuf <= ZERO_WORD;
      r_cancel  <= 1'b0;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_accept) begin
            r_pcReq  <= r_pc;
            r_cancel <= 1'b0;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_respKeep) begin
            r_instBuf <= imem_rdata;
            r_state   <= ST_HOLD;
          end else if (w_respDrop) begin
            r_state <= ST_REQ;
          end else if (redirect) begin
            r_cancel <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            r_instBuf <= ZERO_WORD;
            r_state   <= ST_REQ;
          end else if (!stallF) begin
            r_state <= ST_REQ;
          end
        end
        default: begin
          r_state <= ST_REQ;
        end
      endcase
    end
  end

  // Architectural PC: redirect wins over everything, otherwise it advances
  // only when the held instruction is taken by IF/ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect) begin
      r_pc <= redirect_pc;
    end else if (w_holdRelease) begin
      r_pc <= pcNext(r_pcReq);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_fetchInc  (w_holdRelease),
    .i_cancelInc (w_respDrop),
    .o_fetchCnt  (fetch_cnt),
    .o_cancelCnt (cancel_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: a directed vector table, an issue-rate
// sequence with a 1-cycle memory, and a randomized run against a PC-stream
// reference model with a randomized-latency memory.
// Define FETCH_PERF_CNT_EN to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic        stallF;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pcPlus4F;
  logic [31:0] instF;
  logic        validF;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] cancel_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stallF      (stallF),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pcPlus4F    (pcPlus4F),
    .instF       (instF),
    .validF      (validF)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .cancel_cnt  (cancel_cnt)
`endif
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        chk;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] eInst;
    logic [31:0] ePp4;
  } vecT;

  vecT vecs[33];

  function automatic vecT mkVec(input logic r, input logic s, input logic rd,
                                input logic [31:0] rp, input logic rdy,
                                input logic rv, input logic [31:0] rdat,
                                input logic c, input logic eq,
                                input logic [31:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep);
    vecT v;
    v.rst = r; v.stall = s; v.redir = rd; v.rpc = rp; v.ready = rdy;
    v.rvalid = rv; v.rdata = rdat; v.chk = c; v.eReq = eq; v.eAddr = ea;
    v.eValid = ev; v.eInst = ei; v.ePp4 = ep;
    return v;
  endfunction

  // Contents the memory model returns for a given address
  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vecT v);
    rst         = v.rst;
    stallF      = v.stall;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    imem_ready  = v.ready;
    imem_rvalid = v.rvalid;
    imem_rdata  = v.rdata;
  endtask

  // Random-phase model state
  logic [31:0] expPc;
  logic        pending;
  logic        pendCancelled;
  int          countdown;
  int          delivered;
  int          modelFetchCnt;
  int          modelCancelCnt;
  logic [31:0] rp;
  logic        respNow;
  logic        respNext;
  logic [31:0] respAddr;
  int          validCycles[$];

  initial begin
    rst = 1'b1; stallF = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // ---------------- directed vector table ----------------
    //               rst s  rd rpc            rdy rv rdata          chk req addr           v  inst           pp4
    vecs[0]  = mkVec(1, 0, 0, 32'h0,          0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          32'h0);
    vecs[1]  = mkVec(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 1, RPC,            0, 32'h0,          RPC + 4);
    vecs[2]  = mkVec(0, 0, 0, 32'h0,          0, 1, 32'h2408_0001,  1, 0, RPC,            0, 32'h0,          RPC + 4);
    vecs[3]  = mkVec(0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 0, RPC,            1, 32'h2408_0001,  RPC + 4);
    vecs[4]  = mkVec(0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 0, RPC,            1, 32'h2408_0001,  RPC + 4);
    vecs[5]  = mkVec(0, 1, 0, 32'h0,          1, 1, 32'hDEAD_BEEF,  1, 0, RPC,            1, 32'h2408_0001,  RPC + 4);
    vecs[6]  = mkVec(0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 0, RPC,            1, 32'h2408_0001,  RPC + 4);
    vecs[7]  = mkVec(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 0, RPC,            1, 32'h2408_0001,  RPC + 4);
    vecs[8]  = mkVec(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 1, RPC + 4,        0, 32'h0,          RPC + 8);
    vecs[9]  = mkVec(0, 0, 1, 32'h8000_0100,  0, 0, 32'h0,          1, 0, RPC + 4,        0, 32'h0,          RPC + 8);
    vecs[10] = mkVec(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 32'h8000_0100,  0, 32'h0,          32'h8000_0104);
    vecs[11] = mkVec(0, 0, 0, 32'h0,          0, 1, 32'h1111_1111,  1, 0, 32'h8000_0100,  0, 32'h0,          32'h8000_0104);
    vecs[12] = mkVec(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 1, 32'h8000_0100,  0, 32'h0,          32'h8000_0104);
    vecs[13] = mkVec(0, 0, 1, 32'h8000_0200,  1, 0, 32'h0,          1, 0, 32'h8000_0100,  0, 32'h0,          32'h8000_0104);
    vecs[14] = mkVec(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 1, 32'h8000_0200,  0, 32'h0,          32'h8000_0204);
    vecs[15] = mkVec(0, 0, 1, 32'hFFFF_FFFC,  0, 0, 32'h0,          1, 0, 32'h8000_0200,  0, 32'h0,          32'h8000_0204);
    vecs[16] = mkVec(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  0, 32'h0,          32'h0);
    vecs[17] = mkVec(0, 0, 0, 32'h0,          0, 1, 32'h0C0F_FEE0,  1, 0, 32'hFFFF_FFFC,  0, 32'h0,          32'h0);
    vecs[18] = mkVec(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 32'hFFFF_FFFC,  1, 32'h0C0F_FEE0,  32'h0);
    vecs[19] = mkVec(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 1, 32'h0,          0, 32'h0,          32'h4);
    vecs[20] = mkVec(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 1, 32'h0,          0, 32'h0,          32'h4);
    vecs[21] = mkVec(0, 0, 0, 32'h0,          0, 1, 32'h3333_3333,  1, 0, 32'h0,          0, 32'h0,          32'h4);
    vecs[22] = mkVec(0, 0, 1, 32'h0000_1000,  0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          32'h4);
    vecs[23] = mkVec(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 1, 32'h0000_1000,  0, 32'h0,          32'h0000_1004);
    vecs[24] = mkVec(0, 0, 0, 32'h0,          0, 1, 32'hDEAD_BEEF,  1, 1, 32'h0000_1000,  0, 32'h0,          32'h0000_1004);
    vecs[25] = mkVec(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 1, 32'h0000_1000,  0, 32'h0,          32'h0000_1004);
    vecs[26] = mkVec(0, 0, 1, 32'h0000_2000,  0, 1, 32'h4444_4444,  1, 0, 32'h0000_1000,  0, 32'h0,          32'h0000_1004);
    vecs[27] = mkVec(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 1, 32'h0000_2000,  0, 32'h0,          32'h0000_2004);
    vecs[28] = mkVec(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 1, 32'h0000_2000,  0, 32'h0,          32'h0000_2004);
    vecs[29] = mkVec(0, 0, 0, 32'h0,          0, 1, 32'h5555_5555,  1, 0, 32'h0000_2000,  0, 32'h0,          32'h0000_2004);
    vecs[30] = mkVec(0, 1, 0, 32'h0,          0, 0, 32'h0,          1, 0, 32'h0000_2000,  1, 32'h5555_5555,  32'h0000_2004);
    vecs[31] = mkVec(1, 1, 0, 32'h0,          0, 0, 32'h0,          1, 0, 32'h0000_2000,  1, 32'h5555_5555,  32'h0000_2004);
    vecs[32] = mkVec(0, 1, 0, 32'h0,          0, 0, 32'h0,          1, 1, RPC,            0, 32'h0,          RPC + 4);

    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      if (vecs[i].chk) begin
        checkOutput($sformatf("v%0d.imem_req", i),  {31'b0, imem_req}, {31'b0, vecs[i].eReq});
        checkOutput($sformatf("v%0d.imem_addr", i), imem_addr, vecs[i].eAddr);
        checkOutput($sformatf("v%0d.validF", i),    {31'b0, validF}, {31'b0, vecs[i].eValid});
        checkOutput($sformatf("v%0d.instF", i),     instF, vecs[i].eInst);
        checkOutput($sformatf("v%0d.pcPlus4F", i),  pcPlus4F, vecs[i].ePp4);
      end
`ifdef FETCH_PERF_CNT_EN
      if (i == 30) begin
        checkOutput("fetch_cnt.table", fetch_cnt, 32'd2);
        checkOutput("cancel_cnt.table", cancel_cnt, 32'd2);
      end
      if (i == 32) begin
        checkOutput("fetch_cnt.reset", fetch_cnt, 32'd0);
        checkOutput("cancel_cnt.reset", cancel_cnt, 32'd0);
      end
`endif
    end

    // ---------------- issue rate with a 1-cycle memory ----------------
    @(negedge clk);
    rst = 1'b1; stallF = 1'b0; redirect = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    respNext = 1'b0;
    respAddr = '0;
    validCycles.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rst         = 1'b0;
      imem_ready  = 1'b1;
      imem_rvalid = respNext;
      imem_rdata  = memData(respAddr);
      #1;
      if (validF) begin
        validCycles.push_back(c);
        checkOutput("rate.instF", instF, memData(pcPlus4F - 32'd4));
      end
      respNext = imem_req & imem_ready;
      if (imem_req & imem_ready) respAddr = imem_addr;
    end
    checkOutput("rate.deliveries", (validCycles.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
    if (validCycles.size() >= 3) begin
      checkOutput("rate.firstLatency", validCycles[0], 32'd2);
      checkOutput("rate.interval1", validCycles[1] - validCycles[0], 32'd3);
      checkOutput("rate.interval2", validCycles[2] - validCycles[1], 32'd3);
    end

    // ---------------- randomized run against the PC-stream model ----------------
    @(negedge clk);
    rst = 1'b1; imem_rvalid = 1'b0; imem_ready = 1'b0; stallF = 1'b0; redirect = 1'b0;
    expPc = RPC; pending = 1'b0; pendCancelled = 1'b0; countdown = 0; delivered = 0;
    modelFetchCnt = 0; modelCancelCnt = 0; respAddr = '0;

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 199) == 0);
      stallF   = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 99) < 8);
      rp       = $urandom();
      rp[1:0]  = 2'b00;
      if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFFC;
      redirect_pc = rp;
      imem_ready  = ($urandom_range(0, 9) < 7);
      respNow     = pending && (countdown == 0);
      if (respNow) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memData(respAddr);
      end else if (!pending && ($urandom_range(0, 9) == 0)) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom();
      end
      #1;

      checkOutput("rnd.pcPlus4F", pcPlus4F, expPc + 32'd4);
      if (!validF) checkOutput("rnd.instZero", instF, 32'h0);
      if (redirect) checkOutput("rnd.validUnderRedirect", {31'b0, validF}, 32'd0);
      if (validF) checkOutput("rnd.instData", instF, memData(expPc));
      if (imem_req) begin
        checkOutput("rnd.fetchAddr", imem_addr, expPc);
        checkOutput("rnd.oneOutstanding", {31'b0, pending}, 32'd0);
      end
`ifdef FETCH_PERF_CNT_EN
      checkOutput("rnd.fetch_cnt", fetch_cnt, modelFetchCnt);
      checkOutput("rnd.cancel_cnt", cancel_cnt, modelCancelCnt);
`endif

      // Advance the memory and PC-stream model across the coming edge
      if (respNow) begin
        pending = 1'b0;
        if (redirect || pendCancelled) modelCancelCnt++;
      end else if (pending) begin
        countdown--;
        if (redirect) pendCancelled = 1'b1;
      end
      if (imem_req && imem_ready) begin
        pending       = 1'b1;
        pendCancelled = 1'b0;
        respAddr      = imem_addr;
        countdown     = $urandom_range(0, 2);
      end
      if (redirect) begin
        expPc = rp;
      end else if (validF && !stallF) begin
        expPc = expPc + 32'd4;
        delivered++;
        modelFetchCnt++;
      end
      if (rst) begin
        expPc = RPC; pending = 1'b0; pendCancelled = 1'b0;
        modelFetchCnt = 0; modelCancelCnt = 0;
      end
    end
    checkOutput("rnd.progress", (delivered >= 150) ? 32'd1 : 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
